// File: rtl/controlador_buzzer_pkg.sv
// Shared types for the buzzer controller: pattern codes, FSM states and the
// per-pattern segment table.
package controlador_buzzer_pkg;

    typedef enum logic [1:0] {
        BEEP_SHORT  = 2'd0,
        BEEP_LONG   = 2'd1,
        BEEP_DOUBLE = 2'd2,
        BEEP_ALARM  = 2'd3
    } beep_type_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOn   = 2'd1,
        StOff  = 2'd2,
        StDone = 2'd3
    } state_e;

    localparam int unsigned MaxSegs = 5;
    localparam int unsigned IdxW    = $clog2(MaxSegs + 1);
    localparam int unsigned UnitsW  = 3;

    typedef struct packed {
        logic              on;
        logic [UnitsW-1:0] units;
    } seg_t;

    function automatic logic [IdxW-1:0] seg_count(beep_type_e t);
        logic [IdxW-1:0] n;
        unique case (t)
            BEEP_SHORT:  n = IdxW'(1);
            BEEP_LONG:   n = IdxW'(1);
            BEEP_DOUBLE: n = IdxW'(3);
            BEEP_ALARM:  n = IdxW'(5);
            default:     n = IdxW'(1);
        endcase
        return n;
    endfunction

    // Segments alternate on/off starting with on; entries past the count are unused.
    function automatic seg_t seg_entry(beep_type_e t, logic [IdxW-1:0] idx);
        seg_t s;
        s = '{on: 1'b0, units: UnitsW'(0)};
        unique case (t)
            BEEP_SHORT: begin
                if (idx == IdxW'(0)) s = '{on: 1'b1, units: UnitsW'(1)};
            end
            BEEP_LONG: begin
                if (idx == IdxW'(0)) s = '{on: 1'b1, units: UnitsW'(4)};
            end
            BEEP_DOUBLE: begin
                if (idx == IdxW'(0) || idx == IdxW'(2)) s = '{on: 1'b1, units: UnitsW'(1)};
                else if (idx == IdxW'(1))               s = '{on: 1'b0, units: UnitsW'(1)};
            end
            BEEP_ALARM: begin
                if (idx == IdxW'(0) || idx == IdxW'(2) || idx == IdxW'(4)) begin
                    s = '{on: 1'b1, units: UnitsW'(2)};
                end else if (idx == IdxW'(1) || idx == IdxW'(3)) begin
                    s = '{on: 1'b0, units: UnitsW'(1)};
                end
            end
            default: s = '{on: 1'b0, units: UnitsW'(0)};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/controlador_buzzer_if.sv
// Request/status bundle between the game logic (master) and the buzzer
// controller (slave).
interface controlador_buzzer_if;
    logic       beep_req;
    logic [1:0] beep_type;
    logic       mute;
    logic       buzz_out;
    logic       busy;
    logic       done;

    modport master (
        output beep_req, beep_type, mute,
        input  buzz_out, busy, done
    );

    modport slave (
        input  beep_req, beep_type, mute,
        output buzz_out, busy, done
    );
endinterface

// File: rtl/controlador_buzzer_gerador_tom.sv
// Half-period toggler: phase flips every TONE_HALF enabled cycles; a sync
// clear restarts both counter and phase at 0.
module gerador_tom #(
    parameter int unsigned TONE_HALF = 25000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tone_o,
    output logic tone_next_o
);
    localparam int unsigned CntW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TONE_HALF - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clr_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (en_i) begin
            if (cnt_q == CntLast) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign tone_o      = phase_q;
    // Lets the parent register buzz_out in the same cycle the phase changes.
    assign tone_next_o = phase_d;
endmodule

// File: rtl/controlador_buzzer.sv
// Buzzer controller: plays a table-driven on/off segment pattern per request,
// with a square-wave tone during on segments and busy/done status.
module controlador_buzzer
    import controlador_buzzer_pkg::*;
#(
    parameter int unsigned TONE_HALF   = 25000,
    parameter int unsigned UNIT_CYCLES = 5000000
) (
    input  logic                 clk,
    input  logic                 rst,
    controlador_buzzer_if.slave  bus
);
    localparam int unsigned DurW = $clog2(4 * UNIT_CYCLES + 1);

    state_e          state_q, state_d;
    beep_type_e      type_q, type_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [DurW-1:0] dur_q, dur_d;
    logic            buzz_q, buzz_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    seg_t            seg_cur, seg_nxt, seg_first;
    logic [DurW-1:0] seg_last;
    logic            seg_end;
    logic            last_seg;
    logic            tone_clr, tone_en, tone_unused, tone_next;

    always_comb begin
        seg_cur   = seg_entry(type_q, idx_q);
        seg_nxt   = seg_entry(type_q, idx_q + IdxW'(1));
        seg_first = seg_entry(beep_type_e'(bus.beep_type), IdxW'(0));
        seg_last  = DurW'(seg_cur.units) * DurW'(UNIT_CYCLES) - DurW'(1);
        seg_end   = (state_q == StOn || state_q == StOff) && (dur_q == seg_last);
        last_seg  = (idx_q == seg_count(type_q) - IdxW'(1));
    end

    // Tone restarts at phase 0 at the start of every on segment.
    assign tone_clr = (state_q != StOn) || seg_end;
    assign tone_en  = (state_q == StOn);

    gerador_tom #(
        .TONE_HALF (TONE_HALF)
    ) u_tom (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (tone_clr),
        .en_i        (tone_en),
        .tone_o      (tone_unused),
        .tone_next_o (tone_next)
    );

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        idx_d   = idx_q;
        dur_d   = dur_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.beep_req) begin
                    type_d  = beep_type_e'(bus.beep_type);
                    idx_d   = '0;
                    dur_d   = '0;
                    state_d = seg_first.on ? StOn : StOff;
                end
            end
            StOn, StOff: begin
                if (seg_end) begin
                    dur_d = '0;
                    if (last_seg) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        state_d = seg_nxt.on ? StOn : StOff;
                    end
                end else begin
                    dur_d = dur_q + DurW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StOn) || (state_d == StOff);
        done_d = (state_d == StDone);
        buzz_d = (state_d == StOn) && tone_next && !bus.mute;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            type_q  <= BEEP_SHORT;
            idx_q   <= '0;
            dur_q   <= '0;
            buzz_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            idx_q   <= idx_d;
            dur_q   <= dur_d;
            buzz_q  <= buzz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.buzz_out = buzz_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_controlador_buzzer.sv
// Scoreboard bench for controlador_buzzer: expected {busy, done, buzz_out}
// per cycle is queued from a reference pattern model and compared at negedges.
module tb_controlador_buzzer;
    localparam int unsigned TH = 2;
    localparam int unsigned UC = 8;

    logic clk;
    logic rst;
    controlador_buzzer_if bus ();

    controlador_buzzer #(
        .TONE_HALF   (TH),
        .UNIT_CYCLES (UC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [2:0] exp_q[$];
    int checks;
    int errors;

    // Signed units per segment: >0 on, <0 off, 0 past the end.
    function automatic int seg_units(input int t, input int s);
        case (t)
            0: return (s == 0) ? 1 : 0;
            1: return (s == 0) ? 4 : 0;
            2: return (s == 0 || s == 2) ? 1 : (s == 1) ? -1 : 0;
            3: return (s == 0 || s == 2 || s == 4) ? 2 : (s == 1 || s == 3) ? -1 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic push_pattern(input int t, input bit m);
        int u;
        int len;
        bit tone;
        for (int s = 0; s < 5; s++) begin
            u = seg_units(t, s);
            if (u == 0) break;
            len = ((u < 0) ? -u : u) * UC;
            for (int k = 0; k < len; k++) begin
                tone = ((k / TH) % 2) == 1;
                exp_q.push_back({1'b1, 1'b0, (u > 0) && tone && !m});
            end
        end
        exp_q.push_back(3'b010);
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(3'b000);
    endtask

    task automatic test_reset();
        bus.beep_req  = 1'b0;
        bus.beep_type = 2'd0;
        bus.mute      = 1'b0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.buzz_out} !== 3'b000) begin
            errors++;
            $display("FAIL reset_async got %b want 000", {bus.busy, bus.done, bus.buzz_out});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.buzz_out} !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold got %b want 000", {bus.busy, bus.done, bus.buzz_out});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.buzz_out} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release got %b want 000", {bus.busy, bus.done, bus.buzz_out});
        end
    endtask

    task automatic test_short();
        logic [2:0] e;
        int n;
        @(negedge clk);
        bus.beep_req  = 1'b1;
        bus.beep_type = 2'd0;
        push_pattern(0, 1'b0);
        push_idle(3);
        n = exp_q.size();
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            bus.beep_req = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if ({bus.busy, bus.done, bus.buzz_out} !== e) begin
                errors++;
                $display("FAIL short cycle %0d got %b want %b", i,
                         {bus.busy, bus.done, bus.buzz_out}, e);
            end
        end
    endtask

    task automatic test_double();
        logic [2:0] e;
        int n;
        @(negedge clk);
        bus.beep_req  = 1'b1;
        bus.beep_type = 2'd2;
        push_pattern(2, 1'b0);
        push_idle(2);
        n = exp_q.size();
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            bus.beep_req = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if ({bus.busy, bus.done, bus.buzz_out} !== e) begin
                errors++;
                $display("FAIL double cycle %0d got %b want %b", i,
                         {bus.busy, bus.done, bus.buzz_out}, e);
            end
        end
    endtask

    task automatic test_alarm_mute();
        logic [2:0] e;
        int n;
        @(negedge clk);
        bus.beep_req  = 1'b1;
        bus.beep_type = 2'd3;
        bus.mute      = 1'b1;
        push_pattern(3, 1'b1);
        push_idle(2);
        n = exp_q.size();
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            bus.beep_req = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if ({bus.busy, bus.done, bus.buzz_out} !== e) begin
                errors++;
                $display("FAIL alarm_mute cycle %0d got %b want %b", i,
                         {bus.busy, bus.done, bus.buzz_out}, e);
            end
        end
        bus.mute = 1'b0;
    endtask

    task automatic test_alarm();
        logic [2:0] e;
        int n;
        @(negedge clk);
        bus.beep_req  = 1'b1;
        bus.beep_type = 2'd3;
        push_pattern(3, 1'b0);
        push_idle(2);
        n = exp_q.size();
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            bus.beep_req = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if ({bus.busy, bus.done, bus.buzz_out} !== e) begin
                errors++;
                $display("FAIL alarm cycle %0d got %b want %b", i,
                         {bus.busy, bus.done, bus.buzz_out}, e);
            end
        end
    endtask

    task automatic test_ignored();
        logic [2:0] e;
        int n;
        @(negedge clk);
        bus.beep_req  = 1'b1;
        bus.beep_type = 2'd1;
        push_pattern(1, 1'b0);
        push_idle(4);
        n = exp_q.size();
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({bus.busy, bus.done, bus.buzz_out} !== e) begin
                errors++;
                $display("FAIL ignored cycle %0d got %b want %b", i,
                         {bus.busy, bus.done, bus.buzz_out}, e);
            end
            bus.beep_req  = (i == 10);
            bus.beep_type = (i == 10) ? 2'd0 : 2'd1;
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] e;
        int n;
        @(negedge clk);
        bus.beep_req  = 1'b1;
        bus.beep_type = 2'd0;
        push_pattern(0, 1'b0);
        push_pattern(0, 1'b0);
        push_idle(2);
        n = exp_q.size();
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({bus.busy, bus.done, bus.buzz_out} !== e) begin
                errors++;
                $display("FAIL back_to_back cycle %0d got %b want %b", i,
                         {bus.busy, bus.done, bus.buzz_out}, e);
            end
            // Second request lands in the DONE cycle of the first pattern.
            bus.beep_req = (i == 9);
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] e;
        @(negedge clk);
        bus.beep_req  = 1'b1;
        bus.beep_type = 2'd1;
        push_pattern(1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            bus.beep_req = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if ({bus.busy, bus.done, bus.buzz_out} !== e) begin
                errors++;
                $display("FAIL reset_mid_pre cycle %0d got %b want %b", i,
                         {bus.busy, bus.done, bus.buzz_out}, e);
            end
        end
        exp_q.delete();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.buzz_out} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_async got %b want 000", {bus.busy, bus.done, bus.buzz_out});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.busy, bus.done, bus.buzz_out} !== 3'b000) begin
                errors++;
                $display("FAIL reset_mid_hold step %0d got %b want 000", i,
                         {bus.busy, bus.done, bus.buzz_out});
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.busy, bus.done, bus.buzz_out} !== 3'b000) begin
                errors++;
                $display("FAIL reset_mid_no_done step %0d got %b want 000", i,
                         {bus.busy, bus.done, bus.buzz_out});
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        test_reset();
        test_short();
        test_double();
        test_alarm_mute();
        test_alarm();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        test_short();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
